// File: rtl/trap_seq_pkg.sv
// rtl/trap_seq_pkg.sv - shared encodings for the trap/return sequencer
package trap_seq_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_USER    = 2'b00;
  localparam mode_t MODE_SUPERV  = 2'b01;
  localparam mode_t MODE_MACHINE = 2'b11;

  localparam logic [11:0] CSR_SSTATUS = 12'h100;
  localparam logic [11:0] CSR_SEPC    = 12'h141;
  localparam logic [11:0] CSR_SCAUSE  = 12'h142;
  localparam logic [11:0] CSR_STVAL   = 12'h143;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int ST_SIE    = 1;
  localparam int ST_MIE    = 3;
  localparam int ST_SPIE   = 5;
  localparam int ST_MPIE   = 7;
  localparam int ST_SPP    = 8;
  localparam int ST_MPP_LO = 11;
  localparam int ST_MPP_HI = 12;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_W_EPC    = 3'd1;
  localparam logic [2:0] S_W_CAUSE  = 3'd2;
  localparam logic [2:0] S_W_TVAL   = 3'd3;
  localparam logic [2:0] S_W_STATUS = 3'd4;
  localparam logic [2:0] S_REDIRECT = 3'd5;
  localparam logic [2:0] S_R_STATUS = 3'd6;

endpackage

// File: rtl/trap_status_upd.sv
// rtl/trap_status_upd.sv - status word for trap entry or return at M or S level
module trap_status_upd
  import trap_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] mstatus_i,
  input  logic [1:0]      prev_mode_i,
  input  logic            is_ret_i,
  input  logic            to_super_i,
  output logic [XLEN-1:0] status_o
);

  always_comb begin
    status_o = mstatus_i;
    if (!is_ret_i && !to_super_i) begin
      status_o[ST_MPIE]             = mstatus_i[ST_MIE];
      status_o[ST_MIE]              = 1'b0;
      status_o[ST_MPP_HI:ST_MPP_LO] = prev_mode_i;
    end else if (!is_ret_i) begin
      status_o[ST_SPIE] = mstatus_i[ST_SIE];
      status_o[ST_SIE]  = 1'b0;
      status_o[ST_SPP]  = prev_mode_i[0];
    end else if (!to_super_i) begin
      status_o[ST_MIE]              = mstatus_i[ST_MPIE];
      status_o[ST_MPIE]             = 1'b1;
      status_o[ST_MPP_HI:ST_MPP_LO] = MODE_USER;
    end else begin
      status_o[ST_SIE]  = mstatus_i[ST_SPIE];
      status_o[ST_SPIE] = 1'b1;
      status_o[ST_SPP]  = 1'b0;
    end
  end

endmodule

// File: rtl/trap_seq.sv
// rtl/trap_seq.sv - trap/return sequencer; TRAP_DELEG_EN adds S-mode delegation and sret
module trap_seq
  import trap_seq_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid,
  input  logic            raise_excep,
  input  logic [3:0]      excep_code,
  input  logic            ret,
  input  logic [1:0]      ret_from,
  input  logic [XLEN-1:0] epc,
  input  logic [XLEN-1:0] tval,
  input  logic [XLEN-1:0] mstatus,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
`ifdef TRAP_DELEG_EN
  input  logic [XLEN-1:0] medeleg,
  input  logic [XLEN-1:0] stvec,
  input  logic [XLEN-1:0] sepc,
`endif
  output logic            busy,
  output logic            stall,
  output logic            flush,
  output logic            csr_we,
  output logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            pc_redirect,
  output logic [XLEN-1:0] pc_target,
  output logic [1:0]      mode
);

  logic [2:0]      state_q, state_d;
  mode_t           mode_q, mode_d;
  mode_t           prev_mode_q, prev_mode_d;
  mode_t           new_mode_q, new_mode_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [3:0]      code_q, code_d;
  logic            is_ret_q, is_ret_d;
  logic            super_q, super_d;

  logic            idle, trap_evt, mret_evt, sret_evt, accept, deleg;
  logic [XLEN-1:0] s_tvec, s_epc, status_upd;
  logic            unused_bits;

  assign idle     = (state_q == S_IDLE);
  assign trap_evt = valid & raise_excep;
  assign mret_evt = valid & ret & ~raise_excep & (ret_from == MODE_MACHINE);

`ifdef TRAP_DELEG_EN
  assign sret_evt = valid & ret & ~raise_excep & (ret_from == MODE_SUPERV);
  assign deleg    = (mode_q != MODE_MACHINE) & medeleg[excep_code];
  assign s_tvec   = stvec;
  assign s_epc    = sepc;
`else
  assign sret_evt = 1'b0;
  assign deleg    = 1'b0;
  assign s_tvec   = '0;
  assign s_epc    = '0;
`endif

  // Returns from USER (and SUPERV without delegation) fall through as NOPs.
  assign accept = idle & (trap_evt | mret_evt | sret_evt);

  assign unused_bits = ^{RESET_VEC, mtvec[1:0], s_tvec[1:0]};

  trap_status_upd #(.XLEN(XLEN)) u_status_upd (
    .mstatus_i   (mstatus),
    .prev_mode_i (prev_mode_q),
    .is_ret_i    (is_ret_q),
    .to_super_i  (super_q),
    .status_o    (status_upd)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    prev_mode_d = prev_mode_q;
    new_mode_d  = new_mode_q;
    epc_d       = epc_q;
    tval_d      = tval_q;
    code_d      = code_q;
    is_ret_d    = is_ret_q;
    super_d     = super_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          epc_d       = epc;
          tval_d      = tval;
          code_d      = excep_code;
          prev_mode_d = mode_q;
          is_ret_d    = ~trap_evt;
          super_d     = trap_evt ? deleg : sret_evt;
          state_d     = trap_evt ? S_W_EPC : S_R_STATUS;
        end
      end
      S_W_EPC:    state_d = S_W_CAUSE;
      S_W_CAUSE:  state_d = S_W_TVAL;
      S_W_TVAL:   state_d = S_W_STATUS;
      S_W_STATUS: state_d = S_REDIRECT;
      S_R_STATUS: begin
        new_mode_d = super_q ? {1'b0, mstatus[ST_SPP]} : mstatus[ST_MPP_HI:ST_MPP_LO];
        state_d    = S_REDIRECT;
      end
      S_REDIRECT: begin
        if (is_ret_q) mode_d = new_mode_q;
        else          mode_d = super_q ? MODE_SUPERV : MODE_MACHINE;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mode_q      <= MODE_MACHINE;
      prev_mode_q <= MODE_USER;
      new_mode_q  <= MODE_USER;
      epc_q       <= '0;
      tval_q      <= '0;
      code_q      <= '0;
      is_ret_q    <= 1'b0;
      super_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      prev_mode_q <= prev_mode_d;
      new_mode_q  <= new_mode_d;
      epc_q       <= epc_d;
      tval_q      <= tval_d;
      code_q      <= code_d;
      is_ret_q    <= is_ret_d;
      super_q     <= super_d;
    end
  end

  assign busy  = accept | ~idle;
  assign stall = busy;
  assign flush = accept | (state_q == S_REDIRECT);
  assign mode  = mode_q;

  always_comb begin
    csr_we      = 1'b0;
    csr_addr    = '0;
    csr_wdata   = '0;
    pc_redirect = 1'b0;
    pc_target   = '0;
    case (state_q)
      S_W_EPC: begin
        csr_we    = 1'b1;
        csr_addr  = super_q ? CSR_SEPC : CSR_MEPC;
        csr_wdata = epc_q;
      end
      S_W_CAUSE: begin
        csr_we    = 1'b1;
        csr_addr  = super_q ? CSR_SCAUSE : CSR_MCAUSE;
        csr_wdata = {{(XLEN-4){1'b0}}, code_q};
      end
      S_W_TVAL: begin
        csr_we    = 1'b1;
        csr_addr  = super_q ? CSR_STVAL : CSR_MTVAL;
        csr_wdata = tval_q;
      end
      S_W_STATUS, S_R_STATUS: begin
        csr_we    = 1'b1;
        csr_addr  = super_q ? CSR_SSTATUS : CSR_MSTATUS;
        csr_wdata = status_upd;
      end
      S_REDIRECT: begin
        pc_redirect = 1'b1;
        if (is_ret_q) pc_target = super_q ? s_epc : mepc;
        else          pc_target = super_q ? {s_tvec[XLEN-1:2], 2'b00} : {mtvec[XLEN-1:2], 2'b00};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_seq.sv
// tb/tb_trap_seq.sv - randomized self-checking bench for trap_seq against a transaction-level model
module tb_trap_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0, raise_excep = 1'b0, ret = 1'b0;
  logic [3:0]  excep_code = '0;
  logic [1:0]  ret_from = '0;
  logic [31:0] epc = '0, tval = '0, mstatus = '0, mtvec = '0, mepc = '0;
`ifdef TRAP_DELEG_EN
  logic [31:0] medeleg = '0, stvec = '0, sepc = '0;
`endif
  logic        busy, stall, flush, csr_we, pc_redirect;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, pc_target;
  logic [1:0]  mode;

  trap_seq #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .raise_excep(raise_excep),
    .excep_code(excep_code), .ret(ret), .ret_from(ret_from), .epc(epc),
    .tval(tval), .mstatus(mstatus), .mtvec(mtvec), .mepc(mepc),
`ifdef TRAP_DELEG_EN
    .medeleg(medeleg), .stvec(stvec), .sepc(sepc),
`endif
    .busy(busy), .stall(stall), .flush(flush), .csr_we(csr_we),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .pc_redirect(pc_redirect),
    .pc_target(pc_target), .mode(mode)
  );

  always #5 clk = ~clk;

  // One expected post-accept cycle: a CSR write or the final redirect.
  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [31:0] data;
    logic        redir;
    logic [31:0] tgt;
    logic [1:0]  nmode;
  } exp_t;

  exp_t        exp_q[$];
  logic [1:0]  m_mode = 2'b11;
  logic [43:0] wr_log[$];
  logic [31:0] last_tgt = '0;
  int          busy_cnt = 0, redir_cnt = 0;
  int          n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
  endtask

  function automatic exp_t mk(logic we, logic [11:0] a, logic [31:0] d, logic r, logic [31:0] t, logic [1:0] nm);
    exp_t e;
    e = '{we, a, d, r, t, nm};
    return e;
  endfunction

  task automatic model_accept(output logic took);
    logic [31:0] st;
    logic        dlg;
    logic [11:0] b;
    took = 1'b0;
    if (!valid) return;
    if (raise_excep) begin
      dlg = 1'b0;
`ifdef TRAP_DELEG_EN
      dlg = (m_mode != 2'b11) && medeleg[excep_code];
`endif
      if (dlg) begin
        st = (mstatus & ~32'h122) | ({31'b0, mstatus[1]} << 5) | ({31'b0, m_mode[0]} << 8);
        b  = 12'h100;
      end else begin
        st = (mstatus & ~32'h1888) | ({31'b0, mstatus[3]} << 7) | ({30'b0, m_mode} << 11);
        b  = 12'h300;
      end
      exp_q.push_back(mk(1'b1, b + 12'h41, epc, 1'b0, 32'h0, 2'b00));
      exp_q.push_back(mk(1'b1, b + 12'h42, {28'h0, excep_code}, 1'b0, 32'h0, 2'b00));
      exp_q.push_back(mk(1'b1, b + 12'h43, tval, 1'b0, 32'h0, 2'b00));
      exp_q.push_back(mk(1'b1, b, st, 1'b0, 32'h0, 2'b00));
`ifdef TRAP_DELEG_EN
      if (dlg) exp_q.push_back(mk(1'b0, 12'h0, 32'h0, 1'b1, stvec & 32'hFFFF_FFFC, 2'b01));
      else
`endif
      exp_q.push_back(mk(1'b0, 12'h0, 32'h0, 1'b1, mtvec & 32'hFFFF_FFFC, 2'b11));
      took = 1'b1;
    end else if (ret && ret_from == 2'b11) begin
      st = (mstatus & ~32'h1888) | ({31'b0, mstatus[7]} << 3) | 32'h80;
      exp_q.push_back(mk(1'b1, 12'h300, st, 1'b0, 32'h0, 2'b00));
      exp_q.push_back(mk(1'b0, 12'h0, 32'h0, 1'b1, mepc, mstatus[12:11]));
      took = 1'b1;
    end
`ifdef TRAP_DELEG_EN
    else if (ret && ret_from == 2'b01) begin
      st = (mstatus & ~32'h122) | ({31'b0, mstatus[5]} << 1) | 32'h20;
      exp_q.push_back(mk(1'b1, 12'h100, st, 1'b0, 32'h0, 2'b00));
      exp_q.push_back(mk(1'b0, 12'h0, 32'h0, 1'b1, sepc, {1'b0, mstatus[8]}));
      took = 1'b1;
    end
`endif
  endtask

  // Called just after a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    exp_t e;
    logic took, active;
    #1;
    check("mode", 64'(mode), 64'(m_mode));
    e = '0;
    active = 1'b0;
    took = 1'b0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      active = 1'b1;
    end else begin
      model_accept(took);
    end
    check("busy", 64'(busy), 64'(active | took));
    check("stall", 64'(stall), 64'(active | took));
    check("flush", 64'(flush), 64'(took | e.redir));
    check("csr_we", 64'(csr_we), 64'(e.we));
    check("csr_addr", 64'(csr_addr), 64'(e.addr));
    check("csr_wdata", 64'(csr_wdata), 64'(e.data));
    check("pc_redirect", 64'(pc_redirect), 64'(e.redir));
    check("pc_target", 64'(pc_target), 64'(e.tgt));
    if (csr_we) wr_log.push_back({csr_addr, csr_wdata});
    if (pc_redirect) begin
      last_tgt = pc_target;
      redir_cnt++;
    end
    if (busy) busy_cnt++;
    @(posedge clk);
    if (!rst_n) begin
      exp_q.delete();
      m_mode = 2'b11;
    end else if (e.redir) begin
      m_mode = e.nmode;
    end
    @(negedge clk);
  endtask

  task automatic no_event();
    valid = 1'b0;
    raise_excep = 1'b0;
    ret = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    no_event();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    m_mode = 2'b11;
  endtask

  task automatic mret_to(input logic [1:0] mpp);
    mstatus = {19'h0, mpp, 11'h080};
    mepc = 32'h40;
    valid = 1'b1; ret = 1'b1; ret_from = 2'b11;
    cycle();
    no_event();
    repeat (2) cycle();
  endtask

  initial begin
    do_reset();
    cycle();
    check("reset_mode", 64'(mode), 64'd3);

    // ECALL from USER
    mret_to(2'b00);
    check("user_mode", 64'(mode), 64'd0);
    wr_log.delete();
    mstatus = 32'h8; mtvec = 32'h8000_0001; epc = 32'h100; tval = 32'h0; excep_code = 4'd8;
    valid = 1'b1; raise_excep = 1'b1;
    cycle();
    no_event();
    repeat (6) cycle();
    check("ecall_nwr", 64'(wr_log.size()), 64'd4);
    if (wr_log.size() >= 4) begin
      check("ecall_mepc", 64'(wr_log[0]), 64'({12'h341, 32'h100}));
      check("ecall_mcause", 64'(wr_log[1]), 64'({12'h342, 32'h8}));
      check("ecall_mtval", 64'(wr_log[2]), 64'({12'h343, 32'h0}));
      check("ecall_mstatus", 64'(wr_log[3]), 64'({12'h300, 32'h80}));
    end
    check("ecall_tgt", 64'(last_tgt), 64'h8000_0000);
    check("ecall_mode", 64'(mode), 64'd3);

    // MRET
    wr_log.delete(); busy_cnt = 0;
    mstatus = 32'h1880; mepc = 32'h200;
    valid = 1'b1; ret = 1'b1; ret_from = 2'b11;
    cycle();
    no_event();
    repeat (3) cycle();
    check("mret_nwr", 64'(wr_log.size()), 64'd1);
    if (wr_log.size() >= 1) check("mret_mstatus", 64'(wr_log[0]), 64'({12'h300, 32'h88}));
    check("mret_tgt", 64'(last_tgt), 64'h200);
    check("mret_mode", 64'(mode), 64'd3);
    check("mret_busy_cycles", 64'(busy_cnt), 64'd3);

    // Back-to-back: event held through two full sequences
    wr_log.delete(); redir_cnt = 0;
    mstatus = 32'h0; mtvec = 32'h1000; excep_code = 4'd2;
    valid = 1'b1; raise_excep = 1'b1;
    repeat (12) cycle();
    no_event();
    cycle();
    check("b2b_nwr", 64'(wr_log.size()), 64'd8);
    check("b2b_redirects", 64'(redir_cnt), 64'd2);

    // Reset in W_CAUSE
    redir_cnt = 0;
    excep_code = 4'd5; valid = 1'b1; raise_excep = 1'b1;
    cycle();
    no_event();
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check("rst_we", 64'(csr_we), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mode", 64'(mode), 64'd3);
    repeat (4) cycle();
    check("rst_no_redirect", 64'(redir_cnt), 64'd0);

    // Priority: trap wins over ret; valid gates everything; USER ret is a NOP
    wr_log.delete();
    valid = 1'b1; raise_excep = 1'b1; ret = 1'b1; ret_from = 2'b11; excep_code = 4'd3;
    cycle();
    no_event();
    repeat (5) cycle();
    check("prio_nwr", 64'(wr_log.size()), 64'd4);
    if (wr_log.size() >= 1) check("prio_first_addr", 64'(wr_log[0][43:32]), 64'h341);
    busy_cnt = 0;
    valid = 1'b0; raise_excep = 1'b1;
    repeat (3) cycle();
    valid = 1'b1; raise_excep = 1'b0; ret = 1'b1; ret_from = 2'b00;
    repeat (2) cycle();
    no_event();
    check("gated_busy", 64'(busy_cnt), 64'd0);

`ifdef TRAP_DELEG_EN
    mret_to(2'b00);
    wr_log.delete();
    medeleg = 32'h100; stvec = 32'h4000_0003; mstatus = 32'h2;
    epc = 32'h300; tval = 32'h0; excep_code = 4'd8;
    valid = 1'b1; raise_excep = 1'b1;
    cycle();
    no_event();
    repeat (6) cycle();
    check("deleg_nwr", 64'(wr_log.size()), 64'd4);
    if (wr_log.size() >= 4) begin
      check("deleg_sepc", 64'(wr_log[0]), 64'({12'h141, 32'h300}));
      check("deleg_scause", 64'(wr_log[1]), 64'({12'h142, 32'h8}));
      check("deleg_stval", 64'(wr_log[2]), 64'({12'h143, 32'h0}));
      check("deleg_sstatus", 64'(wr_log[3]), 64'({12'h100, 32'h20}));
    end
    check("deleg_tgt", 64'(last_tgt), 64'h4000_0000);
    check("deleg_mode", 64'(mode), 64'd1);
    medeleg = '0;
`endif

    for (int i = 0; i < 600; i++) begin
      if (exp_q.size() == 0) begin
        mstatus = $urandom; mtvec = $urandom; mepc = $urandom;
`ifdef TRAP_DELEG_EN
        medeleg = $urandom; stvec = $urandom; sepc = $urandom;
`endif
      end
      valid       = ($urandom_range(0, 3) != 0);
      raise_excep = ($urandom_range(0, 3) == 0);
      ret         = ($urandom_range(0, 2) == 0);
      ret_from    = 2'($urandom);
      excep_code  = 4'($urandom);
      epc         = $urandom;
      tval        = $urandom;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
